// File: rtl/dircc_irq_pkg.sv
// Shared definitions for the interrupt controller: register map, ACTIVE field layout
// and the upper bound on source count.
package dircc_irq_pkg;

  localparam int NUM_IRQ_MAX = 16;
  localparam int BUS_W       = 16;
  localparam int ADDR_W      = 3;

  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_RAW      = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE   = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE_SEL = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_COUNT    = 3'd5;

  localparam int ACT_VLD_BIT = 15;
  localparam int ACT_IDX_LSB = 0;
  localparam int ACT_IDX_W   = 4;

  localparam logic [BUS_W-1:0] COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/dircc_irq_controller_if.sv
// Avalon-MM slave bundle (16-bit data, 3-bit word address) for the interrupt controller.
interface dircc_irq_controller_if;
  import dircc_irq_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [BUS_W-1:0]  writedata;
  logic [BUS_W-1:0]  readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/dircc_irq_prio_enc.sv
// Fixed-priority encoder: index of the lowest set request bit, plus an any-set flag.
module dircc_irq_prio_enc
  import dircc_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0]   req_i,
  output logic                 vld_o,
  output logic [ACT_IDX_W-1:0] idx_o
);

  always_comb begin
    vld_o = |req_i;
    idx_o = '0;
    // Scan downwards so the lowest set bit is the last one to write idx_o.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = ACT_IDX_W'(i);
    end
  end

endmodule

// File: rtl/dircc_irq_controller.sv
// Interrupt aggregator: registers NUM_IRQ sources, latches edges or passes levels,
// masks them onto one registered irq and exposes status/mask/mode/ack/stats over Avalon-MM.
module dircc_irq_controller
  import dircc_irq_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dircc_irq_controller_if.slave bus,
  input  logic [NUM_IRQ-1:0]    irq_in,
  output logic                  irq
);

  typedef logic [NUM_IRQ-1:0] vec_t;

  vec_t irq_s_q;
  vec_t edge_q,   edge_d;
  vec_t enable_q, enable_d;
  vec_t esel_q,   esel_d;
  logic             irq_q,   irq_d;
  logic [BUS_W-1:0] count_q, count_d;
  logic [BUS_W-1:0] rdata_q, rdata_d;

  vec_t rise, pending, masked, clr, wvec;
  logic                 wr;
  logic                 act_vld;
  logic [ACT_IDX_W-1:0] act_idx;
  logic                 unused_wdata;

  function automatic logic [BUS_W-1:0] zext(input vec_t v);
    logic [BUS_W-1:0] r;
    r = '0;
    r[NUM_IRQ-1:0] = v;
    return r;
  endfunction

  assign unused_wdata = ^bus.writedata;

  dircc_irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .req_i (masked),
    .vld_o (act_vld),
    .idx_o (act_idx)
  );

  always_comb begin
    wr      = bus.chipselect & ~bus.write_n;
    wvec    = bus.writedata[NUM_IRQ-1:0];
    rise    = irq_in & ~irq_s_q;
    pending = (esel_q & edge_q) | (~esel_q & irq_s_q);
    masked  = pending & enable_q;
    irq_d   = |masked;

    clr      = '0;
    enable_d = enable_q;
    esel_d   = esel_q;
    count_d  = count_q;

    if (irq_d && !irq_q && (count_q != COUNT_MAX)) count_d = count_q + 1'b1;

    if (wr) begin
      unique case (bus.address)
        ADDR_STATUS:   clr = wvec;
        ADDR_ENABLE:   enable_d = wvec;
        ADDR_EDGE_SEL: begin
          esel_d = wvec;
          clr    = ~wvec;
        end
        ADDR_ACTIVE: begin
          // Out-of-range ack indices match no bit and are dropped.
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (bus.writedata[ACT_IDX_W-1:0] == ACT_IDX_W'(i)) clr[i] = 1'b1;
          end
        end
        ADDR_COUNT:    count_d = '0;
        default:       ;
      endcase
    end

    // Set after clear so a simultaneous new edge is never lost.
    edge_d = (edge_q & ~clr) | (rise & esel_q);
  end

  always_comb begin
    rdata_d = '0;
    unique case (bus.address)
      ADDR_STATUS:   rdata_d = zext(masked);
      ADDR_RAW:      rdata_d = zext(pending);
      ADDR_ENABLE:   rdata_d = zext(enable_q);
      ADDR_EDGE_SEL: rdata_d = zext(esel_q);
      ADDR_ACTIVE: begin
        rdata_d[ACT_VLD_BIT]                       = act_vld;
        rdata_d[ACT_IDX_LSB +: ACT_IDX_W]          = act_idx;
      end
      ADDR_COUNT:    rdata_d = count_q;
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_s_q  <= '0;
      edge_q   <= '0;
      enable_q <= '0;
      esel_q   <= '0;
      irq_q    <= 1'b0;
      count_q  <= '0;
      rdata_q  <= '0;
    end else begin
      irq_s_q  <= irq_in;
      edge_q   <= edge_d;
      enable_q <= enable_d;
      esel_q   <= esel_d;
      irq_q    <= irq_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
    end
  end

  assign irq          = irq_q;
  assign bus.readdata = rdata_q;

endmodule

// File: tb/tb_dircc_irq_controller.sv
// Directed bench for dircc_irq_controller: register reads, irq latency, edge/level
// behaviour, ack priority, W1C race, masking, counter saturation and async reset.
module tb_dircc_irq_controller;

  logic       clk;
  logic       reset_n;
  logic [7:0] irq_in;
  logic       irq;
  int         n_pass;
  int         n_total;
  logic [15:0] rd;

  dircc_irq_controller_if bus ();

  dircc_irq_controller #(
    .NUM_IRQ (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(negedge clk);
    d              = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] bits);
    @(negedge clk);
    irq_in = bits;
    @(negedge clk);
    irq_in = 8'h00;
  endtask

  initial begin
    n_pass         = 0;
    n_total        = 0;
    reset_n        = 1'b0;
    irq_in         = 8'h00;
    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 16'h0000;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state: every address reads 0, irq low
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      chk($sformatf("reset_rd%0d", a), rd, 16'h0000);
    end
    chk("reset_irq", {15'd0, irq}, 16'h0000);

    // Level source 0: two-cycle latency up and down, one transition counted
    bus_write(3'd2, 16'h0001);
    @(negedge clk);
    irq_in = 8'h01;
    @(negedge clk);
    chk("lvl_rise_n1", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    chk("lvl_rise_n2", {15'd0, irq}, 16'h0001);
    irq_in = 8'h00;
    @(negedge clk);
    chk("lvl_fall_n1", {15'd0, irq}, 16'h0001);
    @(negedge clk);
    chk("lvl_fall_n2", {15'd0, irq}, 16'h0000);
    bus_read(3'd5, rd);
    chk("count_one", rd, 16'h0001);

    // Edge mode on all, pulses on bits 5 and 2, ack in priority order
    bus_write(3'd3, 16'h00FF);
    bus_write(3'd2, 16'h00FF);
    pulse(8'h24);
    bus_read(3'd0, rd);
    chk("edge_status", rd, 16'h0024);
    bus_read(3'd4, rd);
    chk("edge_active2", rd, 16'h8002);
    bus_write(3'd4, 16'h0002);
    bus_read(3'd4, rd);
    chk("edge_active5", rd, 16'h8005);
    bus_write(3'd4, 16'h0005);
    bus_read(3'd0, rd);
    chk("edge_status_clr", rd, 16'h0000);
    chk("edge_irq_clr", {15'd0, irq}, 16'h0000);
    bus_write(3'd4, 16'h000D);
    bus_read(3'd4, rd);
    chk("ack_oob_idle", rd, 16'h0000);

    // W1C racing a new rise on bit 3: the set wins
    pulse(8'h08);
    bus_read(3'd0, rd);
    chk("race_pre", rd, 16'h0008);
    @(negedge clk);
    irq_in         = 8'h08;
    bus.address    = 3'd0;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = 16'h0008;
    @(negedge clk);
    irq_in         = 8'h00;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus_read(3'd0, rd);
    chk("race_set_wins", rd, 16'h0008);
    bus_write(3'd0, 16'h0008);
    bus_read(3'd0, rd);
    chk("w1c_clears", rd, 16'h0000);

    // Masked edge on bit 1 is visible in RAW only, unmasking raises irq
    bus_write(3'd2, 16'h0000);
    pulse(8'h02);
    bus_read(3'd1, rd);
    chk("mask_raw", rd, 16'h0002);
    bus_read(3'd0, rd);
    chk("mask_status", rd, 16'h0000);
    chk("mask_irq", {15'd0, irq}, 16'h0000);
    bus_write(3'd2, 16'h0002);
    chk("unmask_irq_n1", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    chk("unmask_irq_n2", {15'd0, irq}, 16'h0001);

    // Counter saturation and clear
    bus_write(3'd2, 16'h0000);
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(negedge clk);
    release dut.count_q;
    bus_read(3'd5, rd);
    chk("count_forced", rd, 16'hFFFF);
    bus_write(3'd2, 16'h0002);
    @(negedge clk);
    chk("sat_irq", {15'd0, irq}, 16'h0001);
    bus_read(3'd5, rd);
    chk("count_sat", rd, 16'hFFFF);
    bus_write(3'd5, 16'h1234);
    bus_read(3'd5, rd);
    chk("count_clr", rd, 16'h0000);

    // Asynchronous reset while bit 1 is pending
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("async_rst_irq", {15'd0, irq}, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(3'd2, rd);
    chk("rst_enable", rd, 16'h0000);
    bus_write(3'd3, 16'h00FF);
    bus_read(3'd1, rd);
    chk("rst_latches", rd, 16'h0000);
    chk("rst_irq_after", {15'd0, irq}, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
